wb_bridge_mux: RTL

Parametrised Wishbone bridge/interconnect between one classic-cycle Wishbone master, typically the I2C-to-Wishbone front end, and NSLV Wishbone slaves, typically SPI masters and peripheral register banks. Upper address bits select the slave and lower bits pass through. The bridge registers each request, generates per-slave cyc/stb, returns a single-cycle ack/err/rty to the master and enforces a bus timeout. Interrupts from all slaves are merged into one registered output.

---
 rtl/wb_bridge_pkg.sv | 21 ++
 rtl/wb_timeout_cnt.sv | 27 ++
 rtl/wb_bridge_mux.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the Wishbone bridge/interconnect.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus timeout counter: counts enabled cycles and flags the TIMEOUT-th one.
module wb_timeout_cnt
  import wb_bridge_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Holds at LAST so a stalled enable can never wrap back into range.
  always_ff @(posedge clk) begin
    if (rst || clr)                cnt <= '0;
    else if (en && (cnt != LAST))  cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/wb_bridge_mux.sv
// One classic Wishbone master to NSLV slaves: upper address bits pick the slave,
// request is registered, single-cycle termination returned, bus timeout enforced.
module wb_bridge_mux
  import wb_bridge_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int SLV_AW  = 2,
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  input  logic                 m_we_i,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic                 m_rty_o,
  output logic [SLV_AW-1:0]    s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic                 s_we_o,
  output logic [NSLV-1:0]      s_cyc_o,
  output logic [NSLV-1:0]      s_stb_o,
  input  logic [NSLV*DW-1:0]   s_dat_i,
  input  logic [NSLV-1:0]      s_ack_i,
  input  logic [NSLV-1:0]      s_err_i,
  input  logic [NSLV-1:0]      s_rty_i,
  input  logic [NSLV-1:0]      irq_i,
  output logic                 irq_o
);

  localparam int IW = AW - SLV_AW;
  localparam logic [IW:0] NSLV_L = (IW + 1)'(NSLV);

  state_e            state;
  logic [SLV_AW-1:0] adr_q;
  logic [DW-1:0]     dat_q;
  logic              we_q;
  logic [IW-1:0]     idx_q;

  logic [IW-1:0] idx_in;
  logic          idx_ok;
  logic          sel_ack, sel_err, sel_rty;
  logic [DW-1:0] sel_dat;
  logic          expired;
  logic          rsp_vld;
  rsp_e          rsp;

  assign idx_in = m_adr_i[AW-1:SLV_AW];
  assign idx_ok = {1'b0, idx_in} < NSLV_L;

  // Only the addressed slave may terminate; the others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack = s_ack_i[i];
        sel_err = s_err_i[i];
        sel_rty = s_rty_i[i];
        sel_dat = s_dat_i[i*DW +: DW];
      end
    end
  end

  // A slave response on the expiry edge takes precedence over the timeout.
  always_comb begin
    rsp_vld = sel_ack | sel_err | sel_rty | expired;
    if (sel_ack)      rsp = RSP_ACK;
    else if (sel_err) rsp = RSP_ERR;
    else if (sel_rty) rsp = RSP_RTY;
    else              rsp = RSP_ERR;
  end

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (state != ST_BUS),
    .en      (state == ST_BUS),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_rty_o <= 1'b0;
      irq_o   <= |irq_i;
      case (state)
        ST_IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            adr_q <= m_adr_i[SLV_AW-1:0];
            dat_q <= m_dat_i;
            we_q  <= m_we_i;
            idx_q <= idx_in;
            if (idx_ok) begin
              state <= ST_BUS;
            end else begin
              state   <= ST_RESP;
              m_err_o <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (!m_cyc_i) begin
            state <= ST_IDLE;
          end else if (rsp_vld) begin
            state   <= ST_RESP;
            m_ack_o <= (rsp == RSP_ACK);
            m_err_o <= (rsp == RSP_ERR);
            m_rty_o <= (rsp == RSP_RTY);
            if (sel_ack && !we_q) m_dat_o <= sel_dat;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_adr_o = adr_q;
  assign s_dat_o = dat_q;
  assign s_we_o  = we_q;

  for (genvar g = 0; g < NSLV; g++) begin : g_slv
    assign s_stb_o[g] = (state == ST_BUS) && (idx_q == IW'(g));
    assign s_cyc_o[g] = s_stb_o[g];
  end

endmodule
